// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and write-back.
// Holds one instruction and waits for its data-SRAM response. The response is
// buffered across write-back stalls. Load data is sign/zero-extended.
// Responses that belong to flushed instructions are counted and then dropped.
//
// Optional feature macro: MS_FWD_EN (full forwarding info to decode when
// defined; otherwise decode is told to stall on any dependence).
//
// Ports:
//   clk, resetn             clock, asynchronous active-low reset
//   es_to_ms_valid / ms_allowin          handshake with execute stage
//   es_pc, es_result, es_dest, es_gr_we, es_res_from_mem, es_is_req,
//   es_ld_op, es_ex, es_ertn, es_side_bus  instruction fields from execute
//   es_req_hs               execute-stage SRAM request accepted this cycle
//   data_sram_data_ok/rdata SRAM response
//   wb_ex, wb_ertn          flush from write-back
//   ws_allowin / ms_to_ws_valid          handshake with write-back
//   ms_pc, ms_final_result, ms_dest, ms_gr_we, ms_ex, ms_ertn, ms_side_bus
//   mem_ex, mem_ertn        exception/ertn status back to execute
//   ms_fwd_valid/dest/data/stall         forwarding and stall info to decode
module mem_stage #(
    parameter int unsigned PASS_W = 120
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              es_to_ms_valid,
    output logic              ms_allowin,
    input  logic [31:0]       es_pc,
    input  logic [31:0]       es_result,
    input  logic [4:0]        es_dest,
    input  logic              es_gr_we,
    input  logic              es_res_from_mem,
    input  logic              es_is_req,
    input  logic [4:0]        es_ld_op,
    input  logic              es_ex,
    input  logic              es_ertn,
    input  logic [PASS_W-1:0] es_side_bus,
    input  logic              es_req_hs,
    input  logic              data_sram_data_ok,
    input  logic [31:0]       data_sram_rdata,
    input  logic              wb_ex,
    input  logic              wb_ertn,
    input  logic              ws_allowin,
    output logic              ms_to_ws_valid,
    output logic [31:0]       ms_pc,
    output logic [31:0]       ms_final_result,
    output logic [4:0]        ms_dest,
    output logic              ms_gr_we,
    output logic              ms_ex,
    output logic              ms_ertn,
    output logic [PASS_W-1:0] ms_side_bus,
    output logic              mem_ex,
    output logic              mem_ertn,
    output logic              ms_fwd_valid,
    output logic [4:0]        ms_fwd_dest,
    output logic [31:0]       ms_fwd_data,
    output logic              ms_fwd_stall
);

    localparam int unsigned CNT_W     = 2;
    localparam int unsigned CNT_SUM_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(2);

    // one-hot ld_op bit positions: {ld_b, ld_bu, ld_h, ld_hu, ld_w}
    localparam int unsigned OP_B  = 4;
    localparam int unsigned OP_BU = 3;
    localparam int unsigned OP_H  = 2;
    localparam int unsigned OP_HU = 1;

    logic              ms_valid;
    logic [31:0]       pc_q;
    logic [31:0]       result_q;
    logic [4:0]        dest_q;
    logic              gr_we_q;
    logic              res_from_mem_q;
    logic              is_req_q;
    logic [4:0]        ld_op_q;
    logic              ex_q;
    logic              ertn_q;
    logic [PASS_W-1:0] side_q;

    logic              buf_valid;
    logic [31:0]       buf_data;
    logic [CNT_W-1:0]  cancel_cnt;
    logic [CNT_W-1:0]  cnt_next;

    logic              flush;
    logic              data_ok_live;
    logic              data_got;
    logic              ms_ready_go;
    logic              ms_go;
    logic              ms_accept;
    logic              wait_resp;

    logic [31:0]       rdata_sel;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_ext;

    logic [CNT_SUM_W-1:0] cnt_inc;
    logic [CNT_SUM_W-1:0] cnt_sum;

    assign flush        = wb_ex | wb_ertn;
    // a response while cancels are owed belongs to a flushed instruction
    assign data_ok_live = data_sram_data_ok && (cancel_cnt == '0);
    assign data_got     = buf_valid || data_ok_live;
    assign ms_ready_go  = !is_req_q || ex_q || data_got;
    assign ms_allowin   = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_go        = ms_valid && ms_ready_go && ws_allowin;
    assign ms_accept    = es_to_ms_valid && ms_allowin;
    assign wait_resp    = ms_valid && is_req_q && !buf_valid;

    // pipeline register; flush wins over acceptance
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid       <= 1'b0;
            pc_q           <= '0;
            result_q       <= '0;
            dest_q         <= '0;
            gr_we_q        <= 1'b0;
            res_from_mem_q <= 1'b0;
            is_req_q       <= 1'b0;
            ld_op_q        <= '0;
            ex_q           <= 1'b0;
            ertn_q         <= 1'b0;
            side_q         <= '0;
        end else begin
            if (flush) begin
                ms_valid <= 1'b0;
            end else if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;
            end
            if (ms_accept) begin
                pc_q           <= es_pc;
                result_q       <= es_result;
                dest_q         <= es_dest;
                gr_we_q        <= es_gr_we;
                res_from_mem_q <= es_res_from_mem;
                is_req_q       <= es_is_req;
                ld_op_q        <= es_ld_op;
                ex_q           <= es_ex;
                ertn_q         <= es_ertn;
                side_q         <= es_side_bus;
            end
        end
    end

    // response buffer: holds the live response while write-back stalls
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_valid <= 1'b0;
            buf_data  <= '0;
        end else if (flush || ms_go) begin
            buf_valid <= 1'b0;
        end else if (wait_resp && data_ok_live) begin
            buf_valid <= 1'b1;
            buf_data  <= data_sram_rdata;
        end
    end

    // cancel counter: responses still owed to flushed requests
    always_comb begin
        cnt_inc = '0;
        if (flush) begin
            cnt_inc = CNT_SUM_W'(wait_resp && !data_sram_data_ok) + CNT_SUM_W'(es_req_hs);
        end
        cnt_sum  = {1'b0, cancel_cnt} + cnt_inc
                 - CNT_SUM_W'(data_sram_data_ok && (cancel_cnt != '0));
        cnt_next = (cnt_sum > {1'b0, CNT_MAX}) ? CNT_MAX : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cancel_cnt <= '0;
        end else begin
            cancel_cnt <= cnt_next;
        end
    end

    // load data selection and extension
    always_comb begin
        rdata_sel = buf_valid ? buf_data : data_sram_rdata;
        byte_sel  = rdata_sel[7:0];
        case (result_q[1:0])
            2'd1:    byte_sel = rdata_sel[15:8];
            2'd2:    byte_sel = rdata_sel[23:16];
            2'd3:    byte_sel = rdata_sel[31:24];
            default: byte_sel = rdata_sel[7:0];
        endcase
        half_sel = result_q[1] ? rdata_sel[31:16] : rdata_sel[15:0];
        load_ext = rdata_sel;
        if (ld_op_q[OP_B]) begin
            load_ext = {{24{byte_sel[7]}}, byte_sel};
        end else if (ld_op_q[OP_BU]) begin
            load_ext = {24'd0, byte_sel};
        end else if (ld_op_q[OP_H]) begin
            load_ext = {{16{half_sel[15]}}, half_sel};
        end else if (ld_op_q[OP_HU]) begin
            load_ext = {16'd0, half_sel};
        end
    end

    assign ms_to_ws_valid  = ms_valid && ms_ready_go && !flush;
    assign ms_pc           = pc_q;
    assign ms_final_result = res_from_mem_q ? load_ext : result_q;
    assign ms_dest         = dest_q;
    assign ms_gr_we        = ms_valid & gr_we_q;
    assign ms_ex           = ms_valid & ex_q;
    assign ms_ertn         = ms_valid & ertn_q;
    assign ms_side_bus     = side_q;
    assign mem_ex          = ms_ex;
    assign mem_ertn        = ms_valid & ertn_q;

`ifdef MS_FWD_EN
    assign ms_fwd_valid = ms_valid & gr_we_q;
    assign ms_fwd_dest  = dest_q;
    assign ms_fwd_data  = ms_final_result;
    assign ms_fwd_stall = ms_fwd_valid & res_from_mem_q & !data_got;
`else
    // no forwarding path: decode must stall on any dependence
    assign ms_fwd_valid = 1'b0;
    assign ms_fwd_dest  = '0;
    assign ms_fwd_data  = '0;
    assign ms_fwd_stall = ms_valid & gr_we_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    localparam int unsigned PASS_W = 120;
    localparam logic [4:0] LD_B  = 5'b10000;
    localparam logic [4:0] LD_BU = 5'b01000;
    localparam logic [4:0] LD_H  = 5'b00100;
    localparam logic [4:0] LD_HU = 5'b00010;
    localparam logic [4:0] LD_W  = 5'b00001;

    logic              clk = 1'b0;
    logic              resetn;
    logic              es_to_ms_valid;
    logic              ms_allowin;
    logic [31:0]       es_pc;
    logic [31:0]       es_result;
    logic [4:0]        es_dest;
    logic              es_gr_we;
    logic              es_res_from_mem;
    logic              es_is_req;
    logic [4:0]        es_ld_op;
    logic              es_ex;
    logic              es_ertn;
    logic [PASS_W-1:0] es_side_bus;
    logic              es_req_hs;
    logic              data_sram_data_ok;
    logic [31:0]       data_sram_rdata;
    logic              wb_ex;
    logic              wb_ertn;
    logic              ws_allowin;
    logic              ms_to_ws_valid;
    logic [31:0]       ms_pc;
    logic [31:0]       ms_final_result;
    logic [4:0]        ms_dest;
    logic              ms_gr_we;
    logic              ms_ex;
    logic              ms_ertn;
    logic [PASS_W-1:0] ms_side_bus;
    logic              mem_ex;
    logic              mem_ertn;
    logic              ms_fwd_valid;
    logic [4:0]        ms_fwd_dest;
    logic [31:0]       ms_fwd_data;
    logic              ms_fwd_stall;

    mem_stage #(.PASS_W(PASS_W)) dut (
        .clk(clk), .resetn(resetn),
        .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
        .es_pc(es_pc), .es_result(es_result), .es_dest(es_dest),
        .es_gr_we(es_gr_we), .es_res_from_mem(es_res_from_mem), .es_is_req(es_is_req),
        .es_ld_op(es_ld_op), .es_ex(es_ex), .es_ertn(es_ertn), .es_side_bus(es_side_bus),
        .es_req_hs(es_req_hs), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata), .wb_ex(wb_ex), .wb_ertn(wb_ertn),
        .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc),
        .ms_final_result(ms_final_result), .ms_dest(ms_dest), .ms_gr_we(ms_gr_we),
        .ms_ex(ms_ex), .ms_ertn(ms_ertn), .ms_side_bus(ms_side_bus),
        .mem_ex(mem_ex), .mem_ertn(mem_ertn), .ms_fwd_valid(ms_fwd_valid),
        .ms_fwd_dest(ms_fwd_dest), .ms_fwd_data(ms_fwd_data), .ms_fwd_stall(ms_fwd_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]       pc;
        logic [31:0]       result;
        logic [4:0]        dest;
        logic              gr_we;
        logic              res_from_mem;
        logic              is_req;
        logic [4:0]        ld_op;
        logic              ex;
        logic              ertn;
        logic [PASS_W-1:0] side;
    } instr_t;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: resident instruction, its data if already returned,
    // and the in-order list of outstanding SRAM requests (1 = flushed/dead)
    bit          m_valid = 1'b0;
    instr_t      m;
    bit          m_have  = 1'b0;
    logic [31:0] m_data  = '0;
    bit          q[$];
    instr_t      cur;

    bit c_resp_live, c_ready, c_allowin, c_avail;

    logic        s_to_ws, s_allowin, s_mem_ex, s_stall, s_buf;
    logic [31:0] s_final, s_fwd_data;
    logic [4:0]  s_fwd_dest;
    logic [1:0]  s_cnt;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic instr_t mk(input logic [31:0] pc, input logic [31:0] res,
                                  input logic [4:0] dest, input bit gr_we, input bit rfm,
                                  input bit is_req, input logic [4:0] op, input bit ex,
                                  input bit ertn);
        instr_t i;
        i.pc = pc; i.result = res; i.dest = dest; i.gr_we = gr_we;
        i.res_from_mem = rfm; i.is_req = is_req; i.ld_op = op; i.ex = ex; i.ertn = ertn;
        i.side = {pc, res, ~pc, 24'(dest) ^ 24'h5A5A5A};
        return i;
    endfunction

    // architectural load semantics in plain integer arithmetic
    function automatic logic [31:0] ext(input logic [4:0] op, input logic [1:0] a,
                                        input logic [31:0] w);
        int unsigned b;
        int unsigned h;
        int          v;
        b = (w >> (8 * int'(a))) & 32'hFF;
        h = (a[1] ? (w >> 16) : w) & 32'hFFFF;
        v = int'(w);
        if (op == LD_B)       v = (b >= 128) ? int'(b) - 256 : int'(b);
        else if (op == LD_BU) v = int'(b);
        else if (op == LD_H)  v = (h >= 32768) ? int'(h) - 65536 : int'(h);
        else if (op == LD_HU) v = int'(h);
        return 32'(v);
    endfunction

    function automatic bit has_dead();
        foreach (q[i]) if (q[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_cycle();
        bit          fl, vout;
        logic [31:0] word, exp_final;
        fl          = wb_ex | wb_ertn;
        c_resp_live = data_sram_data_ok && (q.size() != 0) && !q[0];
        c_avail     = m_have || c_resp_live;
        c_ready     = !m.is_req || m.ex || c_avail;
        c_allowin   = !m_valid || (c_ready && ws_allowin);
        word        = m_have ? m_data : data_sram_rdata;
        exp_final   = m.res_from_mem ? ext(m.ld_op, m.result[1:0], word) : m.result;
        vout        = m_valid && c_ready && !fl;

        chk("to_ws_valid", 128'(ms_to_ws_valid), 128'(vout));
        chk("allowin", 128'(ms_allowin), 128'(c_allowin));
        chk("mem_ex", 128'(mem_ex), 128'(m_valid && m.ex));
        chk("mem_ertn", 128'(mem_ertn), 128'(m_valid && m.ertn));
        chk("ms_ex", 128'(ms_ex), 128'(m_valid && m.ex));
        if (vout) begin
            chk("pc", 128'(ms_pc), 128'(m.pc));
            chk("final_result", 128'(ms_final_result), 128'(exp_final));
            chk("dest", 128'(ms_dest), 128'(m.dest));
            chk("gr_we", 128'(ms_gr_we), 128'(m.gr_we));
            chk("ertn", 128'(ms_ertn), 128'(m.ertn));
            chk("side_bus", 128'(ms_side_bus), 128'(m.side));
        end
`ifdef MS_FWD_EN
        chk("fwd_valid", 128'(ms_fwd_valid), 128'(m_valid && m.gr_we));
        chk("fwd_stall", 128'(ms_fwd_stall), 128'(m_valid && m.gr_we && m.res_from_mem && !c_avail));
        if (m_valid && m.gr_we) begin
            chk("fwd_dest", 128'(ms_fwd_dest), 128'(m.dest));
            if (!m.res_from_mem || c_avail)
                chk("fwd_data", 128'(ms_fwd_data), 128'(exp_final));
        end
`else
        chk("fwd_valid", 128'(ms_fwd_valid), 128'(0));
        chk("fwd_dest", 128'(ms_fwd_dest), 128'(0));
        chk("fwd_data", 128'(ms_fwd_data), 128'(0));
        chk("fwd_stall", 128'(ms_fwd_stall), 128'(m_valid && m.gr_we));
`endif
        s_to_ws = ms_to_ws_valid; s_allowin = ms_allowin; s_mem_ex = mem_ex;
        s_stall = ms_fwd_stall; s_final = ms_final_result; s_fwd_data = ms_fwd_data;
        s_fwd_dest = ms_fwd_dest; s_buf = dut.buf_valid; s_cnt = dut.cancel_cnt;
    endtask

    task automatic update_model();
        bit fl, leaving, accept;
        fl      = wb_ex | wb_ertn;
        leaving = m_valid && c_ready && ws_allowin;
        accept  = es_to_ms_valid && c_allowin;
        if (data_sram_data_ok && q.size() != 0) void'(q.pop_front());
        if (fl) begin
            // everything still outstanding now belongs to a dead instruction
            foreach (q[i]) q[i] = 1'b1;
            if (es_req_hs) q.push_back(1'b1);
            m_valid = 1'b0;
            m_have  = 1'b0;
        end else begin
            if (c_resp_live && m_valid && !leaving) begin
                m_have = 1'b1;
                m_data = data_sram_rdata;
            end
            if (leaving) begin
                m_valid = 1'b0;
                m_have  = 1'b0;
            end
            if (accept) begin
                m_valid = 1'b1;
                m       = cur;
                m_have  = 1'b0;
            end
            if (es_req_hs) q.push_back(1'b0);
        end
    endtask

    task automatic cycle(input bit offer, input instr_t ins, input bit resp,
                         input logic [31:0] rd, input bit fl_ex, input bit fl_ertn,
                         input bit wsa, input bit force_hs);
        @(negedge clk);
        cur               = ins;
        es_to_ms_valid    = offer;
        es_pc             = ins.pc;
        es_result         = ins.result;
        es_dest           = ins.dest;
        es_gr_we          = ins.gr_we;
        es_res_from_mem   = ins.res_from_mem;
        es_is_req         = ins.is_req;
        es_ld_op          = ins.ld_op;
        es_ex             = ins.ex;
        es_ertn           = ins.ertn;
        es_side_bus       = ins.side;
        data_sram_data_ok = resp && (q.size() != 0);
        data_sram_rdata   = rd;
        wb_ex             = fl_ex;
        wb_ertn           = fl_ertn;
        ws_allowin        = wsa;
        es_req_hs         = 1'b0;
        #1;
        es_req_hs = force_hs | (offer && ins.is_req && ms_allowin);
        #1;
        check_cycle();
        @(posedge clk);
        update_model();
    endtask

    function automatic instr_t rnd_instr();
        int          k;
        logic [4:0]  op;
        logic [31:0] pc, res;
        logic [4:0]  d;
        k   = $urandom_range(0, 9);
        op  = 5'(1 << $urandom_range(0, 4));
        pc  = $urandom;
        res = $urandom;
        d   = 5'($urandom);
        if (k < 4)       return mk(pc, res, d, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        else if (k < 7)  return mk(pc, res, d, 1'b1, 1'b1, 1'b1, op, 1'b0, 1'b0);
        else if (k < 8)  return mk(pc, res, d, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        else if (k < 9)  return mk(pc, res, d, 1'($urandom), 1'b1, 1'b0, op, 1'b1, 1'b0);
        else             return mk(pc, res, d, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t idle, ins;
        idle = mk(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        m    = idle;
        cur  = idle;
        resetn = 1'b0;
        es_to_ms_valid = 0; es_pc = 0; es_result = 0; es_dest = 0; es_gr_we = 0;
        es_res_from_mem = 0; es_is_req = 0; es_ld_op = 0; es_ex = 0; es_ertn = 0;
        es_side_bus = '0; es_req_hs = 0; data_sram_data_ok = 0; data_sram_rdata = 0;
        wb_ex = 0; wb_ertn = 0; ws_allowin = 1;

        // reset values
        repeat (2) @(negedge clk);
        chk("rst allowin", 128'(ms_allowin), 128'(1));
        chk("rst to_ws_valid", 128'(ms_to_ws_valid), 128'(0));
        chk("rst final_result", 128'(ms_final_result), 128'(0));
        chk("rst mem_ex", 128'(mem_ex), 128'(0));
        chk("rst fwd_stall", 128'(ms_fwd_stall), 128'(0));
        chk("rst cancel_cnt", 128'(dut.cancel_cnt), 128'(0));
        resetn = 1'b1;

        // ld_b / ld_bu at 0x1003
        cycle(1, mk(32'h100, 32'h1003, 5'd3, 1, 1, 1, LD_B, 0, 0), 0, 0, 0, 0, 1, 0);
        cycle(0, idle, 1, 32'h80FF_FF12, 0, 0, 1, 0);
        chk("ld_b valid", 128'(s_to_ws), 128'(1));
        chk("ld_b value", 128'(s_final), 128'(32'hFFFF_FF80));
        cycle(1, mk(32'h104, 32'h1003, 5'd3, 1, 1, 1, LD_BU, 0, 0), 0, 0, 0, 0, 1, 0);
        cycle(0, idle, 1, 32'h80FF_FF12, 0, 0, 1, 0);
        chk("ld_bu value", 128'(s_final), 128'(32'h0000_0080));

        // ld_h at 0x1002 with write-back stalled after the response
        cycle(1, mk(32'h108, 32'h1002, 5'd4, 1, 1, 1, LD_H, 0, 0), 0, 0, 0, 0, 1, 0);
        cycle(0, idle, 1, 32'h8001_0000, 0, 0, 0, 0);
        chk("ld_h value", 128'(s_final), 128'(32'hFFFF_8001));
        for (int i = 0; i < 3; i++) begin
            cycle(0, idle, 0, 32'hAAAA_5555, 0, 0, 0, 0);
            chk("ld_h held value", 128'(s_final), 128'(32'hFFFF_8001));
            chk("ld_h buf_valid", 128'(s_buf), 128'(1));
            chk("ld_h held valid", 128'(s_to_ws), 128'(1));
        end
        cycle(0, idle, 0, 0, 0, 0, 1, 0);

        // flush while a load waits plus an accepted request: two responses dropped
        cycle(1, mk(32'h200, 32'h2000, 5'd6, 1, 1, 1, LD_W, 0, 0), 0, 0, 0, 0, 1, 0);
        cycle(0, idle, 0, 0, 1, 0, 1, 1);
        cycle(1, mk(32'h300, 32'h3000, 5'd7, 1, 1, 1, LD_W, 0, 0), 0, 0, 0, 0, 1, 0);
        chk("cancel_cnt after flush", 128'(s_cnt), 128'(2));
        cycle(0, idle, 1, 32'hDEAD_0001, 0, 0, 1, 0);
        chk("stale resp 1 ignored", 128'(s_to_ws), 128'(0));
        cycle(0, idle, 1, 32'hDEAD_0002, 0, 0, 1, 0);
        chk("stale resp 2 ignored", 128'(s_to_ws), 128'(0));
        cycle(0, idle, 1, 32'h1234_5678, 0, 0, 1, 0);
        chk("own resp valid", 128'(s_to_ws), 128'(1));
        chk("own resp value", 128'(s_final), 128'(32'h1234_5678));
        chk("cancel_cnt drained", 128'(s_cnt), 128'(0));

        // ALU instruction, single-cycle residency
        cycle(1, mk(32'h400, 32'hDEAD_BEEF, 5'd8, 1, 0, 0, 5'd0, 0, 0), 0, 0, 0, 0, 1, 0);
        chk("alu allowin in", 128'(s_allowin), 128'(1));
        cycle(0, idle, 0, 0, 0, 0, 1, 0);
        chk("alu valid", 128'(s_to_ws), 128'(1));
        chk("alu value", 128'(s_final), 128'(32'hDEAD_BEEF));
        chk("alu allowin", 128'(s_allowin), 128'(1));

        // excepting load without a request passes without waiting
        cycle(1, mk(32'h500, 32'h5000, 5'd9, 1, 1, 0, LD_W, 1, 0), 0, 0, 0, 0, 0, 0);
        cycle(0, idle, 0, 0, 0, 0, 0, 0);
        chk("ex valid", 128'(s_to_ws), 128'(1));
        chk("ex mem_ex", 128'(s_mem_ex), 128'(1));
        cycle(0, idle, 0, 0, 0, 0, 1, 0);
        chk("ex mem_ex held", 128'(s_mem_ex), 128'(1));
        cycle(0, idle, 0, 0, 0, 0, 1, 0);
        chk("ex mem_ex gone", 128'(s_mem_ex), 128'(0));

        // forwarding view of an outstanding load to r5
        cycle(1, mk(32'h600, 32'h6000, 5'd5, 1, 1, 1, LD_B, 0, 0), 0, 0, 0, 0, 1, 0);
        cycle(0, idle, 0, 0, 0, 0, 1, 0);
        chk("fwd stall waiting", 128'(s_stall), 128'(1));
        cycle(0, idle, 1, 32'h0000_00F0, 0, 0, 1, 0);
`ifdef MS_FWD_EN
        chk("fwd stall released", 128'(s_stall), 128'(0));
        chk("fwd data", 128'(s_fwd_data), 128'(32'hFFFF_FFF0));
        chk("fwd dest", 128'(s_fwd_dest), 128'(5));
`else
        chk("fwd stall any dep", 128'(s_stall), 128'(1));
`endif
        cycle(0, idle, 0, 0, 0, 0, 1, 0);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            bit fl, fe;
            ins = rnd_instr();
            fl  = ($urandom_range(0, 19) == 0) && !has_dead();
            fe  = 1'($urandom);
            cycle(1'($urandom_range(0, 3) != 0), ins, 1'($urandom), $urandom,
                  fl && fe, fl && !fe, $urandom_range(0, 9) < 7, 0);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage sitting directly downstream of the execute stage and upstream of write-back. Holds one instruction, waits for the data-SRAM response of loads/stores whose request was accepted upstream, buffers that response across write-back stalls, sign/zero-extends load data, and drops responses belonging to flushed instructions. Also reports its exception/ertn status upstream and provides forwarding/stall information to decode.

## Interface
Parameters:
- PASS_W, 120, width of opaque side bus carried unchanged (CSR info, rj/rkd values, exception codes)

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- es_to_ms_valid  in  1  execute stage offers an instruction
- ms_allowin  out  1  stage can accept this cycle
- es_pc / es_result  in  32 each  PC; ALU result (= memory address for ld/st)
- es_dest  in  5  destination register
- es_gr_we / es_res_from_mem / es_is_req  in  1 each  writes GR; result is load data; instruction issued an SRAM request
- es_ld_op  in  5  one-hot {ld_b, ld_bu, ld_h, ld_hu, ld_w}
- es_ex / es_ertn  in  1 each  instruction carries exception / is ertn
- es_side_bus  in  PASS_W  passthrough
- es_req_hs  in  1  execute stage's request accepted (req & addr_ok) this cycle
- data_sram_data_ok  in  1  response strobe
- data_sram_rdata  in  32  response data
- wb_ex / wb_ertn  in  1 each  flush from write-back
- ws_allowin  in  1  write-back can accept
- ms_to_ws_valid  out  1  offer to write-back
- ms_pc / ms_final_result  out  32 each
- ms_dest  out  5;  ms_gr_we / ms_ex / ms_ertn  out  1 each
- ms_side_bus  out  PASS_W
- mem_ex / mem_ertn  out  1 each  to execute stage (suppress its store strobes)
- ms_fwd_valid  out  1;  ms_fwd_dest  out  5;  ms_fwd_data  out  32;  ms_fwd_stall  out  1

## Operation
- Pipeline register: ms_valid plus latched fields. Load on es_to_ms_valid && ms_allowin. ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
- flush = wb_ex | wb_ertn: ms_valid <= 0 next cycle, overriding acceptance.
- ms_ready_go = !is_req || ms_ex || data_got, where data_got = buffered response present or (data_ok && cancel_cnt==0).
- Response buffer: data_ok with cancel_cnt==0 while ms_valid && is_req && !buf_valid -> if not leaving this cycle, store rdata in buf, buf_valid<=1. buf_valid clears when instruction leaves or on flush.
- Cancel counter (2 bits): on flush, increment by (ms_valid && is_req && !buf_valid && !data_ok) + es_req_hs. Any data_ok while cancel_cnt>0 decrements and is ignored. Max value 2; never wraps.
- Load extension uses rdata_sel = buf_valid ? buf : rdata and addr = result[1:0]: ld_b/bu selects byte addr, sign/zero-extend; ld_h/hu selects half addr[1]; ld_w whole word. ms_final_result = res_from_mem ? extended : result.
- ms_ex = ms_valid & ex; mem_ex = ms_ex; mem_ertn = ms_valid & ertn. ms_to_ws_valid = ms_valid && ms_ready_go && !flush.

## Timing
- Reset: ms_valid, buf_valid, cancel_cnt = 0; all outputs 0 except ms_allowin = 1.
- Non-memory instruction: one cycle residency when ws_allowin=1.
- Load: data_ok in cycle N -> ms_to_ws_valid in cycle N (combinational path from rdata), result via buffer from N+1 if stalled.
- data_ok may arrive at earliest the cycle after es_req_hs; simultaneous data_ok and flush for a live request consumes the response (no cancel increment).
- Reset mid-operation clears cancel_cnt; stray responses after reset are the interconnect's responsibility.

## Configuration
- MS_FWD_EN defined: ms_fwd_valid = ms_valid & gr_we; ms_fwd_dest = dest; ms_fwd_data = ms_final_result; ms_fwd_stall = ms_fwd_valid & res_from_mem & !data_got.
- Undefined: ms_fwd_valid/dest/data tied 0; ms_fwd_stall = ms_valid & gr_we (decode stalls on any dependence).

## Test plan
- ld_b at address 0x1003, rdata 0x80FF_FF12, data_ok next cycle -> ms_final_result 0xFFFF_FF80; ld_bu -> 0x0000_0080.
- ld_h at 0x1002, rdata 0x8001_0000, ws_allowin held 0 for 3 cycles after data_ok -> result 0xFFFF_8001 presented stable, buf_valid 1 throughout.
- wb_ex while load waiting plus es_req_hs same cycle -> cancel_cnt 2; next two data_ok ignored; following load gets its own rdata 0x1234_5678.
- ALU instruction, result 0xDEAD_BEEF, ws_allowin 1 -> ms_to_ws_valid one cycle later, ms_allowin stays 1.
- es_ex=1 load with es_is_req=0 -> passes without waiting; mem_ex=1 while resident.
- With MS_FWD_EN: outstanding load dest r5 -> ms_fwd_stall=1 until data_ok, then ms_fwd_data = extended value.
